// File: rtl/rect_cordic.sv
// Iterative rotation-mode CORDIC: polar (amplitude, phase) in, rectangular (re, im) out.
// One micro-rotation per clock; the amplitude is pre-scaled by the CORDIC gain at load.
module rect_cordic #(
  parameter int ITER = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [8:0]        ampli_in,
  input  logic signed [9:0] theta_in,
  input  logic              trig,
  output logic signed [9:0] re_out,
  output logic signed [9:0] im_out,
  output logic              busy,
  output logic              vld
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, ROT, OUT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt;
  logic signed [19:0]    x, y;
  logic signed [15:0]    z;

  // Load-time values: gain-compensated amplitude and quadrant fold
  logic [17:0]           ak;
  logic                  fold;
  logic signed [19:0]    x0;
  logic signed [15:0]    z0;

  // Scaling by K = 0.607253 (Q0.16) lands the amplitude directly on the 2^-14 grid
  assign ak   = 18'((25'(ampli_in) * 25'd39797) >> 7);
  assign fold = (theta_in > 10'sd256) || (theta_in < -10'sd256);
  assign x0   = fold ? -$signed({2'b00, ak}) : $signed({2'b00, ak});
  // Adding or subtracting pi (512 LSB) on a 10-bit phase is just an MSB flip
  assign z0   = fold ? {~theta_in[9], theta_in[8:0], 6'b0} : {theta_in, 6'b0};

  function automatic logic signed [15:0] atan_rom(input logic [3:0] i);
    case (i)
      4'd0:    return 16'sd8192;
      4'd1:    return 16'sd4836;
      4'd2:    return 16'sd2555;
      4'd3:    return 16'sd1297;
      4'd4:    return 16'sd651;
      4'd5:    return 16'sd326;
      4'd6:    return 16'sd163;
      4'd7:    return 16'sd81;
      4'd8:    return 16'sd41;
      4'd9:    return 16'sd20;
      4'd10:   return 16'sd10;
      4'd11:   return 16'sd5;
      4'd12:   return 16'sd3;
      4'd13:   return 16'sd1;
      default: return 16'sd0;
    endcase
  endfunction

  // Round to nearest on the Q4.5 grid, then clamp symmetrically to +/-511
  function automatic logic signed [9:0] sat_round(input logic signed [19:0] v);
    logic signed [20:0] t;
    logic signed [11:0] r;
    t = 21'(v) + 21'sd256;
    r = 12'(t >>> 9);
    if (r > 12'sd511)       return 10'sd511;
    else if (r < -12'sd511) return -10'sd511;
    else                    return r[9:0];
  endfunction

  logic signed [19:0] xs, ys, x_nxt, y_nxt;
  logic signed [15:0] atan, z_nxt;

  always_comb begin
    xs   = x >>> cnt;
    ys   = y >>> cnt;
    atan = atan_rom(4'(cnt));
    if (!z[15]) begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - atan;
    end else begin
      x_nxt = x + ys;
      y_nxt = y - xs;
      z_nxt = z + atan;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // NOTE: next-state starts from the current state so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig) state_d = ROT;
      ROT:     if (cnt == CW'(ITER - 1)) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x      <= '0;
      y      <= '0;
      z      <= '0;
      cnt    <= '0;
      re_out <= '0;
      im_out <= '0;
      busy   <= 1'b0;
      vld    <= 1'b0;
    end else begin
      vld <= 1'b0;
      case (state_q)
        IDLE: if (trig) begin
          x    <= x0;
          y    <= '0;
          z    <= z0;
          cnt  <= '0;
          busy <= 1'b1;
        end
        ROT: begin
          x   <= x_nxt;
          y   <= y_nxt;
          z   <= z_nxt;
          cnt <= cnt + 1'b1;
        end
        OUT: begin
          re_out <= sat_round(x);
          im_out <= sat_round(y);
          vld    <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_cordic.sv
// Self-checking bench for rect_cordic: directed vectors, handshake/reset sequences,
// and a strided amplitude x phase sweep against a floating-point reference.
module tb_rect_cordic;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [8:0]        ampli_in;
  logic signed [9:0] theta_in;
  logic              trig;
  logic signed [9:0] re_out, im_out;
  logic              busy, vld;

  int checks   = 0;
  int failures = 0;

  rect_cordic #(.ITER(12)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .ampli_in (ampli_in),
    .theta_in (theta_in),
    .trig     (trig),
    .re_out   (re_out),
    .im_out   (im_out),
    .busy     (busy),
    .vld      (vld)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [8:0]        a;
    logic signed [9:0] th;
    int                re;
    int                im;
    int                tol;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge where vld was seen
  // (or after a 40-cycle bound). lat counts edges after the trig-accept edge.
  task automatic run_op(input logic [8:0] a, input logic signed [9:0] th, output int lat);
    ampli_in = a;
    theta_in = th;
    trig     = 1'b1;
    @(posedge sys_clk); #1;
    trig     = 1'b0;
    ampli_in = 9'($urandom);
    theta_in = 10'($urandom);
    check("busy_after_trig", int'(busy), 1, 0);
    lat = 0;
    while (!vld && lat < 40) begin
      @(posedge sys_clk); #1;
      lat++;
    end
  endtask

  function automatic int ref_re(input int a, input int th);
    return int'(real'(a) * $cos(real'(th) * 3.14159265358979 / 512.0));
  endfunction

  function automatic int ref_im(input int a, input int th);
    return int'(real'(a) * $sin(real'(th) * 3.14159265358979 / 512.0));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nv, first;

    vecs[0] = '{a: 9'd32,  th: 10'sd0,    re: 32,   im: 0,    tol: 1};
    vecs[1] = '{a: 9'd320, th: 10'sd128,  re: 226,  im: 226,  tol: 1};
    vecs[2] = '{a: 9'd320, th: -10'sd384, re: -226, im: -226, tol: 1};
    vecs[3] = '{a: 9'd511, th: -10'sd512, re: -511, im: 0,    tol: 1};
    vecs[4] = '{a: 9'd511, th: 10'sd256,  re: 0,    im: 511,  tol: 1};
    vecs[5] = '{a: 9'd0,   th: 10'sd137,  re: 0,    im: 0,    tol: 0};
    vecs[6] = '{a: 9'd100, th: -10'sd128, re: 71,   im: -71,  tol: 1};
    vecs[7] = '{a: 9'd200, th: 10'sd170,  re: 101,  im: 173,  tol: 2};
    vecs[8] = '{a: 9'd511, th: 10'sd511,  re: -511, im: 3,    tol: 2};

    sys_rst_n = 1'b0;
    trig      = 1'b0;
    ampli_in  = '0;
    theta_in  = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_re", int'(re_out), 0, 0);
    check("reset_im", int'(im_out), 0, 0);
    check("reset_busy", int'(busy), 0, 0);
    check("reset_vld", int'(vld), 0, 0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].th, lat);
      check($sformatf("vec%0d_latency", i), lat, 13, 0);
      check($sformatf("vec%0d_re", i), int'(re_out), vecs[i].re, vecs[i].tol);
      check($sformatf("vec%0d_im", i), int'(im_out), vecs[i].im, vecs[i].tol);
      check($sformatf("vec%0d_range", i),
            int'(re_out == -10'sd512 || im_out == -10'sd512), 0, 0);
      check($sformatf("vec%0d_busy_low", i), int'(busy), 0, 0);
      @(posedge sys_clk); #1;
      check($sformatf("vec%0d_vld_one_cycle", i), int'(vld), 0, 0);
      check($sformatf("vec%0d_hold_re", i), int'(re_out), vecs[i].re, vecs[i].tol);
      check($sformatf("vec%0d_hold_im", i), int'(im_out), vecs[i].im, vecs[i].tol);
    end

    // Trig pulsed while busy is ignored
    ampli_in = 9'd32;
    theta_in = 10'sd0;
    trig     = 1'b1;
    @(posedge sys_clk); #1;
    trig  = 1'b0;
    nv    = 0;
    first = -1;
    for (int c = 1; c <= 40; c++) begin
      trig = (c == 5);
      @(posedge sys_clk); #1;
      if (vld) begin
        nv++;
        if (first < 0) first = c;
      end
    end
    trig = 1'b0;
    check("busy_trig_vld_count", nv, 1, 0);
    check("busy_trig_latency", first, 13, 0);
    check("busy_trig_re", int'(re_out), 32, 1);

    // Trig in the vld cycle is accepted: next vld 14 clocks later
    run_op(9'd320, 10'sd128, lat);
    check("b2b_first_latency", lat, 13, 0);
    ampli_in = 9'd100;
    theta_in = -10'sd128;
    trig     = 1'b1;
    @(posedge sys_clk); #1;
    trig = 1'b0;
    nv   = 1;
    while (!vld && nv < 40) begin
      @(posedge sys_clk); #1;
      nv++;
    end
    check("b2b_spacing", nv, 14, 0);
    check("b2b_re", int'(re_out), 71, 1);
    check("b2b_im", int'(im_out), -71, 1);

    // Reset during rotation aborts the operation
    ampli_in = 9'd511;
    theta_in = 10'sd256;
    trig     = 1'b1;
    @(posedge sys_clk); #1;
    trig = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("abort_re", int'(re_out), 0, 0);
    check("abort_im", int'(im_out), 0, 0);
    check("abort_busy", int'(busy), 0, 0);
    check("abort_vld", int'(vld), 0, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge sys_clk); #1;
      if (vld) nv++;
    end
    check("abort_no_vld", nv, 0, 0);
    run_op(9'd32, 10'sd0, lat);
    check("after_abort_latency", lat, 13, 0);
    check("after_abort_re", int'(re_out), 32, 1);
    check("after_abort_im", int'(im_out), 0, 1);

    // Strided sweep of amplitude x phase against the reference
    for (int ai = 0; ai < 14; ai++) begin
      int a_val;
      a_val = (ai == 13) ? 511 : ai * 37;
      for (int tj = 0; tj < 16; tj++) begin
        int t_val;
        t_val = -512 + tj * 67;
        run_op(9'(a_val), 10'(t_val), lat);
        check($sformatf("sweep_lat a=%0d t=%0d", a_val, t_val), lat, 13, 0);
        check($sformatf("sweep_re a=%0d t=%0d", a_val, t_val),
              int'(re_out), ref_re(a_val, t_val), 2);
        check($sformatf("sweep_im a=%0d t=%0d", a_val, t_val),
              int'(im_out), ref_im(a_val, t_val), 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_cordic.md
# rect_cordic

- Iterative CORDIC in rotation mode: converts a polar sample (amplitude, phase) to rectangular (re, im).
- It is the inverse of the block's vectoring-mode sibling and uses the same number formats, so the two chain back-to-back.
- It sits on the same trig/vld handshake as the sibling, performs one micro-rotation per clock, and pre-scales by the CORDIC gain so outputs need no correction.

## Interface
- ITER, 12, number of micro-rotations (legal 8..14)
- sys_clk  in  1  clock; all state changes on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- ampli_in  in  9  unsigned amplitude, Q4.5 (value = ampli_in/32)
- theta_in  in  10  signed phase, LSB = π/512 rad, range [-π, π)
- trig  in  1  start pulse; sampled only in IDLE
- re_out  out  10  signed real part, Q4.5
- im_out  out  10  signed imaginary part, Q4.5
- busy  out  1  high from the trig-accept edge until vld
- vld  out  1  one-cycle result strobe

## Operation
- Reset: state IDLE; re_out=0, im_out=0, busy=0, vld=0; all internal registers are cleared.
- States: IDLE -> ROT (trig=1) -> OUT (after ITER iterations) -> IDLE.
- Load, on the trig edge in IDLE:
  - Inputs are captured at this edge only; they may change afterwards.
  - Gain pre-scale: ak = (ampli_in*39797) >>> 7, with K=0.607253 in Q0.16.
  - Internal x/y are 20-bit signed, LSB = 2^-14 (9 guard bits below Q4.5).
  - Internal z is 16-bit signed, LSB = π/32768 (theta_in << 6).
- Quadrant fold, applied at load:
  - theta_in > 256: z0 = (theta_in-512)<<6, x0 = -ak.
  - theta_in < -256: z0 = (theta_in+512)<<6, x0 = -ak.
  - Otherwise: z0 = theta_in<<6, x0 = ak.
  - y0 = 0 in all cases.
  - theta_in = ±256 is not folded.
- ROT iteration i (i = 0..ITER-1, one per clock):
  - d = +1 if z ≥ 0, else -1.
  - x' = x - d·(y>>>i); y' = y + d·(x>>>i); z' = z - d·atan_i.
  - atan_i = round(atan(2^-i)·32768/π); e.g. atan_0 = 8192, atan_1 = 4836, atan_2 = 2555. The table is constant ROM indexed by the iteration counter.
- OUT:
  - re_out = sat((x + 256) >>> 9); im_out likewise from y. Rounding is to nearest.
  - Saturation range is [-511, +511].
  - Outputs are registered together with vld=1, then the state returns to IDLE.
- re_out and im_out hold their value until the next OUT; they are not cleared when vld drops.
- trig while busy=1 is ignored; no queueing.
- ampli_in = 0 yields exactly re_out = im_out = 0 for any theta_in.

## Timing
- Trig sampled at edge E0; iterations occur on edges E1..E_ITER; outputs and vld are registered at edge E_(ITER+1).
- Latency: vld is high in the cycle after E_(ITER+1), i.e. ITER+1 clocks after trig (13 for the default ITER).
- vld lasts exactly one cycle; busy falls at the same edge where vld rises.
- In the vld cycle the state is IDLE, so a trig there is accepted. Back-to-back throughput is one result per ITER+2 clocks.
- Asynchronous reset mid-ROT/OUT:
  - Aborts immediately; outputs, busy and vld go to 0.
  - No vld is produced for the aborted operation.
  - The first trig after release starts normally.

## Test plan
- Unity at zero phase: ampli_in=32, theta_in=0 -> re_out=32±1, im_out=0±1; vld exactly 13 clocks after trig, for one cycle.
- 45°: ampli_in=320, theta_in=128 -> re_out=im_out=226±1. Also ampli_in=320, theta_in=-384 -> re_out=im_out=-226±1 (fold path).
- Boundaries:
  - ampli_in=511, theta_in=-512 -> re_out=-511±1, im_out=0±1.
  - ampli_in=511, theta_in=256 -> re_out=0±1, im_out=511±1; verify the value never exceeds ±511.
- Zero amplitude: ampli_in=0, theta_in=137 -> re_out=0, im_out=0 exactly.
- Handshake and reset:
  - Trig pulsed at clock 5 of busy -> ignored, one vld only.
  - Trig in the vld cycle -> second vld 14 clocks after the first.
  - sys_rst_n low at iteration 6 -> vld never asserted; re_out=im_out=0, busy=0.
- Exhaustive sweep: all ampli_in 0..511 × theta_in -512..511, each result compared against round(A·cos θ), round(A·sin θ). Pass criterion: max error ≤ 2 LSB on both outputs, and vld observed for every trig.
